// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the MDU: op codes, default latencies, op-class helpers.
// MDU_MADD_EN enables the madd/msub family as start-class ops.
package cpu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } mdu_state_e;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    function automatic logic is_md_start(input md_op_e op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_md_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply / divide / accumulate for e_mdu.
// The HI/LO accumulator inputs exist only when MDU_MADD_EN is defined.
module mdu_arith
    import cpu_pkg::*;
(
`ifdef MDU_MADD_EN
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
`endif
    input  md_op_e      i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic [63:0] o_result,
    output logic        o_div_zero
);

    logic [63:0] w_rs_sx;
    logic [63:0] w_rt_sx;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_sgn;
    logic        w_dz;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign w_rs_sx  = {{32{i_rs[31]}}, i_rs};
    assign w_rt_sx  = {{32{i_rt[31]}}, i_rt};
    assign w_prod_s = w_rs_sx * w_rt_sx;
    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

    // Signed divide runs on magnitudes so INT_MIN/-1 stays well defined.
    assign w_sgn = (i_op == MD_DIV);
    assign w_dz  = (i_rt == 32'd0);
    assign w_a   = (w_sgn && i_rs[31]) ? (~i_rs + 32'd1) : i_rs;
    assign w_b   = (w_sgn && i_rt[31]) ? (~i_rt + 32'd1) : i_rt;
    assign w_q   = w_dz ? 32'd0 : (w_a / w_b);
    assign w_r   = w_dz ? 32'd0 : (w_a % w_b);
    assign w_quo = (w_sgn && (i_rs[31] ^ i_rt[31])) ? (~w_q + 32'd1) : w_q;
    assign w_rem = (w_sgn && i_rs[31]) ? (~w_r + 32'd1) : w_r;

    always_comb begin
        o_result = '0;
        case (i_op)
            MD_MULT:         o_result = w_prod_s;
            MD_MULTU:        o_result = w_prod_u;
            MD_DIV, MD_DIVU: o_result = {w_rem, w_quo};
`ifdef MDU_MADD_EN
            MD_MADD:         o_result = {i_hi, i_lo} + w_prod_s;
            MD_MADDU:        o_result = {i_hi, i_lo} + w_prod_u;
            MD_MSUB:         o_result = {i_hi, i_lo} - w_prod_s;
            MD_MSUBU:        o_result = {i_hi, i_lo} - w_prod_u;
`endif
            default:         o_result = '0;
        endcase
    end

    assign o_div_zero = is_md_div(i_op) && w_dz;

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: private HI/LO, multi-cycle mult/div, mf*/mt* in EX.
// MDU_MADD_EN adds madd/maddu/msub/msubu with MULT_CYCLES latency.
module e_mdu
    import cpu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    mdu_state_e  r_state;
    mdu_state_e  w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [63:0] r_pending;
    logic        r_pend_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    md_op_e      w_op;
    logic        w_start;
    logic [63:0] w_result;
    logic        w_div_zero;
    logic        w_hi_we;
    logic        w_lo_we;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;

    assign w_op = md_op_e'(md_op);

    mdu_arith u_arith (
`ifdef MDU_MADD_EN
        .i_hi       (r_hi),
        .i_lo       (r_lo),
`endif
        .i_op       (w_op),
        .i_rs       (rs_val),
        .i_rt       (rt_val),
        .o_result   (w_result),
        .o_div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_pend_dz <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_start) begin
                r_pending <= w_result;
                r_pend_dz <= w_div_zero;
            end
            if (w_hi_we) r_hi <= w_hi_nxt;
            if (w_lo_we) r_lo <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_we     = 1'b0;
        w_lo_we     = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = is_md_div(w_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end else if (w_op == MD_MTHI) begin
                    w_hi_we  = 1'b1;
                    w_hi_nxt = rs_val;
                end else if (w_op == MD_MTLO) begin
                    w_lo_we  = 1'b1;
                    w_lo_nxt = rs_val;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    // A zero divisor still burns the full latency but leaves HI/LO alone.
                    if (!r_pend_dz) begin
                        w_hi_we  = 1'b1;
                        w_lo_we  = 1'b1;
                        w_hi_nxt = r_pending[63:32];
                        w_lo_nxt = r_pending[31:0];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start  = is_md_start(w_op) && (r_state == S_IDLE);
        busy     = (r_state == S_RUN);
        md_rdata = '0;
        if (w_op == MD_MFHI)      md_rdata = r_hi;
        else if (w_op == MD_MFLO) md_rdata = r_lo;
    end

    assign start = w_start;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: vector table with a result scoreboard plus corner sequences.
module tb_e_mdu;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        md_op_e      op;
        logic [31:0] rs, rt, pre_hi, pre_lo, hi, lo;
        int unsigned cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        int unsigned cyc;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .start    (start),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_rdata (md_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input string name, input md_op_e op,
                                   input logic [31:0] rs, rt, pre_hi, pre_lo, ehi, elo,
                                   input int unsigned cyc);
        vec_t v;
        v.name = name; v.op = op; v.rs = rs; v.rt = rt;
        v.pre_hi = pre_hi; v.pre_lo = pre_lo; v.hi = ehi; v.lo = elo; v.cyc = cyc;
        return v;
    endfunction

    task automatic mt(input md_op_e op, input logic [31:0] v);
        @(negedge clk);
        md_op = op; rs_val = v;
        @(negedge clk);
        md_op = MD_NONE;
    endtask

    // Presents op for one cycle; returns at the negedge of the first busy cycle.
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_start, input string name);
        @(negedge clk);
        md_op = op; rs_val = a; rt_val = b;
        #1;
        check({name, " start"}, 32'(start), 32'(exp_start));
        @(negedge clk);
        md_op = MD_NONE;
    endtask

    task automatic wait_done(output int unsigned n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int unsigned n;
        exp_t e;

        vecs[0] = mkvec("mult_neg",  MD_MULT,  32'hFFFFFFFD, 32'd5,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        vecs[1] = mkvec("divu_7_2",  MD_DIVU,  32'd7,        32'd2,        32'h0,  32'h0,  32'd1,        32'd3,        10);
        vecs[2] = mkvec("div_m7_2",  MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        vecs[3] = mkvec("div_zero",  MD_DIV,   32'd9,        32'd0,        32'hA,  32'hB,  32'hA,        32'hB,        10);
        vecs[4] = mkvec("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,  32'hFFFFFFFE, 32'h00000001, 5);
        vecs[5] = mkvec("div_7_m2",  MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,  32'd1,        32'hFFFFFFFD, 10);
        vecs[6] = mkvec("mult_min",  MD_MULT,  32'h80000000, 32'h80000000, 32'h0,  32'h0,  32'h40000000, 32'h0,        5);
        vecs[7] = mkvec("divu_big",  MD_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0,  32'h0,  32'hF,        32'h0FFFFFFF, 10);
        vecs[8] = mkvec("multu_z",   MD_MULTU, 32'h1234,     32'h0,        32'h55, 32'h66, 32'h0,        32'h0,        5);

        reset = 1'b1; md_op = MD_NONE; rs_val = '0; rt_val = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst start", 32'(start), 32'd0);
        check("rst rdata", md_rdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            mt(MD_MTHI, vecs[i].pre_hi);
            mt(MD_MTLO, vecs[i].pre_lo);
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b1, vecs[i].name);
            sb.push_back('{hi: vecs[i].hi, lo: vecs[i].lo, cyc: vecs[i].cyc});
            wait_done(n);
            e = sb.pop_front();
            check({vecs[i].name, " cycles"}, n, e.cyc);
            check({vecs[i].name, " hi"}, hi, e.hi);
            check({vecs[i].name, " lo"}, lo, e.lo);
        end

        // Ops presented while busy are ignored; then mf* reads the completed result.
        issue(MD_MULT, 32'hFFFFFFFD, 32'd5, 1'b1, "mult2");
        md_op = MD_MULT; rs_val = 32'd100; rt_val = 32'd100;
        #1;
        check("busy start", 32'(start), 32'd0);
        @(negedge clk);
        md_op = MD_MTHI; rs_val = 32'hDEADBEEF;
        @(negedge clk);
        md_op = MD_NONE;
        wait_done(n);
        check("mult2 hi", hi, 32'hFFFFFFFF);
        check("mult2 lo", lo, 32'hFFFFFFF1);
        md_op = MD_MFLO;
        #1;
        check("mflo", md_rdata, 32'hFFFFFFF1);

        @(negedge clk);
        md_op = MD_MTHI; rs_val = 32'h12345678;
        @(negedge clk);
        md_op = MD_MFHI;
        #1;
        check("mthi hi", hi, 32'h12345678);
        check("mthi lo kept", lo, 32'hFFFFFFF1);
        check("mfhi", md_rdata, 32'h12345678);
        md_op = MD_NONE;
        #1;
        check("none rdata", md_rdata, 32'd0);

        // Reset in the third busy cycle discards the in-flight product.
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "multu_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst mid busy", 32'(busy), 32'd0);
        check("rst mid hi", hi, 32'd0);
        check("rst mid lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check("rst late hi", hi, 32'd0);
        check("rst late lo", lo, 32'd0);
        check("rst late busy", 32'(busy), 32'd0);

        mt(MD_MTLO, 32'd1);
`ifdef MDU_MADD_EN
        issue(MD_MADD, 32'd2, 32'd3, 1'b1, "madd");
        sb.push_back('{hi: 32'd0, lo: 32'd7, cyc: 5});
        wait_done(n);
        e = sb.pop_front();
        check("madd cycles", n, e.cyc);
        check("madd hi", hi, e.hi);
        check("madd lo", lo, e.lo);
`else
        issue(MD_MADD, 32'd2, 32'd3, 1'b0, "madd_off");
        check("madd_off busy", 32'(busy), 32'd0);
        md_op = MD_MADD;
        #1;
        check("madd_off rdata", md_rdata, 32'd0);
        md_op = MD_NONE;
        repeat (7) @(negedge clk);
        check("madd_off hi", hi, 32'd0);
        check("madd_off lo", lo, 32'd1);
        check("madd_off busy late", 32'(busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
